// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: built-in self-test initiator for a single-port RAM.
//
// Runs a four-phase march over every address:
//   W0 writes E(a), R0 reads and expects E(a),
//   W1 writes ~E(a), R1 reads and expects ~E(a),
// where E(a) = (a zero-extended/truncated to DW bits) ^ PAT.
// Each read is tracked through an RD_LAT-deep compare pipeline so that the
// returning ram_out word is checked against the word that was expected for it.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   start      single-cycle request to begin a run (ignored while busy)
//   ram_out    read data returned by the RAM
//   ram_data   write data to the RAM
//   ram_add    address to the RAM
//   ram_we     RAM write enable, active high
//   busy       run in progress
//   done       run finished, held until the next accepted start
//   pass       valid while done=1; 1 when no mismatch was seen
//   err_cnt    mismatch count, saturating at all-ones
//   fail_addr  address of the first mismatch of the run
//
// Build option:
//   BIST_STOP_ON_FAIL_EN  when defined, the first mismatch ends the run at
//                         once (err_cnt=1, pass=0); otherwise the full march
//                         always completes and counts every mismatch.
//
// State  | meaning
// -------+-------------------------------------------------
// IDLE   | after reset, waiting for start
// W0     | write E(a) to every address
// R0     | read every address, expect E(a)
// W1     | write ~E(a) to every address
// R1     | read every address, expect ~E(a)
// DRAIN  | RD_LAT cycles to retire the reads still in flight
// DONE   | result held, waiting for the next start

module ram_bist_ctrl #(
    parameter int              DW     = 4,
    parameter int              AW     = 4,
    parameter logic [DW-1:0]   PAT    = DW'(4'h5),
    parameter int              RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] ram_out,
    output logic [DW-1:0] ram_data,
    output logic [AW-1:0] ram_add,
    output logic          ram_we,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW+1:0] err_cnt,
    output logic [AW-1:0] fail_addr
);

    localparam int            EW   = AW + 2;
    localparam logic [AW-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [DW-1:0] ram_data_d;
    logic [AW-1:0] ram_add_d;
    logic          ram_we_d, busy_d, done_d, pass_d;
    logic [EW-1:0] err_cnt_d, err_nxt;
    logic [AW-1:0] fail_addr_d;
    logic [1:0]    drain_cnt, drain_cnt_d;

    // compare pipeline: one entry per issued read
    logic [RD_LAT-1:0] pipe_vld;
    logic [AW-1:0]     pipe_addr [RD_LAT];
    logic [DW-1:0]     pipe_exp  [RD_LAT];
    logic              push_vld, flush;
    logic [DW-1:0]     push_exp;
    logic              mism;

    function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
        return DW'(a) ^ PAT;
    endfunction

    assign mism    = pipe_vld[RD_LAT-1] && (ram_out != pipe_exp[RD_LAT-1]);
    assign err_nxt = (mism && err_cnt != '1) ? err_cnt + EW'(1) : err_cnt;

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ram_data  <= '0;
            ram_add   <= '0;
            ram_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            drain_cnt <= '0;
        end else begin
            state_q   <= state_d;
            ram_data  <= ram_data_d;
            ram_add   <= ram_add_d;
            ram_we    <= ram_we_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            err_cnt   <= err_cnt_d;
            fail_addr <= fail_addr_d;
            drain_cnt <= drain_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= push_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_addr[0] <= ram_add;
        pipe_exp[0]  <= push_exp;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_addr[i] <= pipe_addr[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)           state_d = W0;
            W0:         if (ram_add == LAST) state_d = R0;
            R0:         if (ram_add == LAST) state_d = W1;
            W1:         if (ram_add == LAST) state_d = R1;
            R1:         if (ram_add == LAST) state_d = DRAIN;
            DRAIN:      if (drain_cnt == '0) state_d = DONE;
            default:                         state_d = IDLE;
        endcase
`ifdef BIST_STOP_ON_FAIL_EN
        if (mism) state_d = DONE;
`endif
    end

    // output logic: next values of the registered outputs
    always_comb begin
        ram_data_d  = ram_data;
        ram_add_d   = ram_add;
        ram_we_d    = ram_we;
        busy_d      = busy;
        done_d      = done;
        pass_d      = pass;
        err_cnt_d   = err_nxt;
        fail_addr_d = (mism && err_cnt == '0) ? pipe_addr[RD_LAT-1] : fail_addr;
        drain_cnt_d = drain_cnt;
        push_vld    = 1'b0;
        push_exp    = '0;
        flush       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                ram_we_d  = 1'b0;
                busy_d    = 1'b0;
                ram_add_d = '0;
                if (start) begin
                    err_cnt_d   = '0;
                    fail_addr_d = '0;
                    pass_d      = 1'b0;
                    done_d      = 1'b0;
                    busy_d      = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_data_d  = exp_word('0);
                end
            end
            W0: begin
                if (ram_add == LAST) begin
                    ram_add_d = '0;
                    ram_we_d  = 1'b0;
                end else begin
                    ram_add_d  = ram_add + AW'(1);
                    ram_data_d = exp_word(ram_add + AW'(1));
                end
            end
            R0: begin
                push_vld = 1'b1;
                push_exp = exp_word(ram_add);
                if (ram_add == LAST) begin
                    // first W1 write is issued straight out of R0
                    ram_add_d  = '0;
                    ram_we_d   = 1'b1;
                    ram_data_d = ~exp_word('0);
                end else begin
                    ram_add_d = ram_add + AW'(1);
                end
            end
            W1: begin
                if (ram_add == LAST) begin
                    ram_add_d = '0;
                    ram_we_d  = 1'b0;
                end else begin
                    ram_add_d  = ram_add + AW'(1);
                    ram_data_d = ~exp_word(ram_add + AW'(1));
                end
            end
            R1: begin
                push_vld = 1'b1;
                push_exp = ~exp_word(ram_add);
                if (ram_add == LAST) begin
                    ram_add_d   = '0;
                    drain_cnt_d = 2'(RD_LAT - 1);
                end else begin
                    ram_add_d = ram_add + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    // last compare retires on this same edge, so use err_nxt
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_nxt == '0);
                end else begin
                    drain_cnt_d = drain_cnt - 2'd1;
                end
            end
            default: begin
                ram_we_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

`ifdef BIST_STOP_ON_FAIL_EN
        if (mism) begin
            ram_we_d  = 1'b0;
            ram_add_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            push_vld  = 1'b0;
            flush     = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b1;
    logic [DW-1:0] ram_out;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_add;
    logic          ram_we, busy, done, pass;
    logic [AW+1:0] err_cnt;
    logic [AW-1:0] fail_addr;

    ram_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram_out   (ram_out),
        .ram_data  (ram_data),
        .ram_add   (ram_add),
        .ram_we    (ram_we),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // RAM model: synchronous read, one cycle latency, stuck-at-0 bits on read
    logic [DW-1:0] mem        [DEPTH];
    logic [DW-1:0] fault_mask [DEPTH];

    always @(posedge clk) begin
        if (ram_we) mem[ram_add] <= ram_data;
        ram_out <= mem[ram_add] & ~fault_mask[ram_add];
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          pass;
        logic [AW+1:0] err;
        logic [AW-1:0] fail;
        int            busy_lo;
        int            busy_hi;
    } res_t;

    wr_t  wr_q [$];
    res_t res_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compares every write and every run result against the queues
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    int   busy_cnt  = 0;
    wr_t  w;
    res_t r;

    always @(negedge clk) begin
        if (busy) busy_cnt = busy_prev ? busy_cnt + 1 : 1;
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", ram_add, ram_data);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", 32'(ram_add), 32'(w.addr));
                check("wr_data", 32'(ram_data), 32'(w.data));
            end
        end
        if (done && !done_prev) begin
            if (res_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done=1 expected no result");
            end else begin
                r = res_q.pop_front();
                check("pass", 32'(pass), 32'(r.pass));
                check("err_cnt", 32'(err_cnt), 32'(r.err));
                check("fail_addr", 32'(fail_addr), 32'(r.fail));
                n_checks++;
                if (busy_cnt < r.busy_lo || busy_cnt > r.busy_hi) begin
                    n_errors++;
                    $display("FAIL busy_cycles: got %0d expected %0d..%0d", busy_cnt, r.busy_lo, r.busy_hi);
                end
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    // expected traffic: W0 writes a^5, W1 writes ~(a^5)
    task automatic push_run(input bit full, input logic exp_pass, input logic [AW+1:0] exp_err,
                            input logic [AW-1:0] exp_fail, input int lo, input int hi);
        logic [AW-1:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            a = AW'(i);
            wr_q.push_back('{addr: a, data: a ^ 4'h5});
        end
        if (full) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = AW'(i);
                wr_q.push_back('{addr: a, data: ~(a ^ 4'h5)});
            end
        end
        res_q.push_back('{pass: exp_pass, err: exp_err, fail: exp_fail, busy_lo: lo, busy_hi: hi});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            tick();
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s_timeout: got done=0 expected done=1 within 300 cycles", name);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]        = '0;
            fault_mask[i] = '0;
        end

        // reset held with start asserted: everything stays 0
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  32'({ram_data, ram_add, ram_we, busy, done, pass, err_cnt, fail_addr}), 32'h0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        // fault-free run
        push_run(1'b1, 1'b1, '0, '0, 65, 65);
        pulse_start();
        check("start_busy", 32'({busy, done}), 32'h2);
        wait_done("clean");

        // bit2 stuck-at-0 at address 9: R0 mismatch only
        fault_mask[9] = 4'b0100;
        push_run(1'b1, 1'b0, 6'd1, 4'd9, 65, 65);
        pulse_start();
        wait_done("fault9");

        // restart clears the result; a start mid-run is ignored
        fault_mask[9] = 4'b0000;
        push_run(1'b1, 1'b1, '0, '0, 65, 65);
        pulse_start();
        check("restart_clears", 32'({done, pass, err_cnt, fail_addr}), 32'h0);
        repeat (9) tick();
        pulse_start();
        wait_done("ignored_start");

        // identical rerun
        push_run(1'b1, 1'b1, '0, '0, 65, 65);
        pulse_start();
        wait_done("rerun");

        // reset inside R0 aborts the run with no result
        push_run(1'b1, 1'b1, '0, '0, 65, 65);
        pulse_start();
        repeat (29) tick();
        rst = 1'b1;
        tick();
        check("abort_outputs", 32'({ram_we, busy, done}), 32'h0);
        rst = 1'b0;
        check("abort_pending_writes", 32'(wr_q.size()), 32'd16);
        wr_q.delete();
        res_q.delete();
        tick();
        push_run(1'b1, 1'b1, '0, '0, 65, 65);
        pulse_start();
        wait_done("after_abort");

        // faults at addresses 3 and 9
        fault_mask[3] = 4'b0100;
        fault_mask[9] = 4'b0100;
`ifdef BIST_STOP_ON_FAIL_EN
        push_run(1'b0, 1'b0, 6'd1, 4'd3, 1, 64);
`else
        push_run(1'b1, 1'b0, 6'd2, 4'd3, 65, 65);
`endif
        pulse_start();
        wait_done("fault3_9");

        repeat (4) tick();
        check("writes_left", 32'(wr_q.size()), 32'd0);
        check("results_left", 32'(res_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
